gpio_led_driver: RTL
====================

Name: gpio_led_driver

Overview:
- Downstream consumer of the Murax SoC GPIO-A write word; drives the 8 board LEDs.
- Adds per-LED enable, per-LED blink, 16-level global PWM brightness and a selectable blink rate.
- Firmware controls all of this with a single 32-bit GPIO write.
- Config is shadowed and applied only at PWM period boundaries, so brightness changes are glitch-free.

Parameters:
- PRESCALE_DIV, 50, clk_50MHz cycles per PWM tick (min 1; default gives a 1 MHz tick).
- NUM_LEDS, 8, LED count (the field layout below is fixed for 8).

Ports:
- clk_50MHz  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- gpio_write  in  32  GPIO-A write word from the SoC.
- leds  out  8  LED drive, registered, active-high.
- pwm_sync  out  1  one-cycle pulse at each PWM period start.

Behaviour:
- Clocking and reset: one clock, clk_50MHz. Reset is synchronous and active-high on rst.
- gpio_write field map:
  - [7:0] en: per-LED enable.
  - [15:8] blink: per-LED blink select.
  - [19:16] lvl: brightness 0..15.
  - [22:20] rate: blink rate 0..7.
  - [31:23] ignored.
- Stage 1: gpio_write[22:0] registered every cycle into cfg_live.
- Prescaler:
  - presc_cnt counts 0..PRESCALE_DIV-1 and wraps.
  - tick=1 in the cycle where presc_cnt==PRESCALE_DIV-1.
  - PRESCALE_DIV=1 gives tick every cycle.
- PWM counter:
  - 8-bit pwm_cnt increments on tick; wraps 255->0.
  - wrap event = tick && pwm_cnt==255.
- On wrap event, same edge:
  - cfg_shadow <= cfg_live.
  - blk_cnt (14-bit, free-running, wraps) increments.
  - pwm_sync <= 1 for exactly one cycle; otherwise 0.
- Duty:
  - duty = lvl*17 (0..255), from cfg_shadow.
  - pwm_on = (pwm_cnt < duty) || (duty==255).
  - lvl=0 gives always off; lvl=15 gives always on.
- Blink phase: phase = blk_cnt[rate+6], so half-period = 2^(rate+6) PWM periods.
  - rate=0: 64 periods, 16.4 ms at default.
  - rate=7: 8192 periods, ~2.1 s.
- Output: leds[i] <= en[i] && (!blink[i] || phase) && pwm_on, registered, one cycle after pwm_cnt/shadow.
- Latency:
  - A gpio_write change first affects leds within 1 + 256*PRESCALE_DIV + 1 cycles.
  - Mid-period changes never alter the current period.
- Simultaneous events: a gpio_write change on the wrap-event cycle is not captured, because cfg_live lags by one cycle; it applies at the next wrap.
- Reset values: leds=0, pwm_sync=0, presc_cnt=0, pwm_cnt=0, blk_cnt=0, cfg_live=0, cfg_shadow=0.
- Reset mid-operation: all state returns to reset values on the first rst edge. leds=0 from that edge. Counting restarts from 0 on the first cycle rst is low.
- No state machine beyond the counters.

Optional Feature:
- Macro: LED_GAMMA_EN.
- Defined: duty comes from a 16-entry gamma LUT indexed by lvl: 0,1,2,4,6,9,13,18,25,34,46,62,84,113,152,255.
- Undefined: linear duty = lvl*17.
- With or without the macro: lvl=0 is off and lvl=15 is full-on (255).

Test Plan (benches use PRESCALE_DIV=1, so 1 period = 256 cycles):
- Hold rst 10 cycles with gpio_write=0xFFFF_FFFF -> leds=0x00 and pwm_sync=0 throughout. First pwm_sync 256 cycles after rst release (pwm_cnt wraps at 255).
- gpio_write=0x000F_00FF -> after the next pwm_sync, leds=0xFF steady every cycle.
- gpio_write=0x0008_0001, linear -> after the sync, leds[0]=1 for 136 cycles then 0 for 120, repeating; leds[7:1]=0. With LED_GAMMA_EN: 25 on / 231 off.
- gpio_write=0x000F_0303 (rate 0) -> leds[1:0]=0b11 for 64 periods, 0b00 for 64 periods, repeating (16384-cycle half-period); leds[7:2]=0.
- In steady state 0x000F_00FF, write 0x0000_00FF at pwm_cnt=100 -> leds stay 0xFF until the next pwm_sync, then 0x00 from the following cycle.
- Assert rst for 1 cycle mid-blink -> leds=0 on the next edge; blink phase and period restart from 0; cfg must be re-captured (the first period after reset is all-off).

Source files
------------

// File: rtl/gpio_led_if.sv
// gpio_led_if: SoC-side bundle for the LED driver.
//   gpio_write : GPIO-A write word from the SoC (32 bits)
//   leds       : registered LED drive, active-high (NUM_LEDS bits)
//   pwm_sync   : one-cycle pulse at each PWM period start
// master = SoC / stimulus side, slave = gpio_led_driver.
interface gpio_led_if #(
  parameter int unsigned NUM_LEDS = 8
);
  logic [31:0]         gpio_write;
  logic [NUM_LEDS-1:0] leds;
  logic                pwm_sync;

  modport master (
    output gpio_write,
    input  leds,
    input  pwm_sync
  );

  modport slave (
    input  gpio_write,
    output leds,
    output pwm_sync
  );
endinterface

// File: rtl/gpio_led_driver.sv
// gpio_led_driver: drives the board LEDs from the Murax GPIO-A write word.
// It provides per-LED enable, per-LED blink, 16-level global PWM brightness
// and a selectable blink rate. Configuration is shadowed at PWM period
// boundaries, so brightness changes never glitch mid-period.
//
// Ports:
//   clk_50MHz : system clock (only clock)
//   rst       : synchronous reset, active-high
//   bus       : gpio_led_if.slave
//                 gpio_write[7:0]   en     per-LED enable
//                 gpio_write[15:8]  blink  per-LED blink select
//                 gpio_write[19:16] lvl    brightness 0..15
//                 gpio_write[22:20] rate   blink half-period 2^(rate+6) PWM periods
//                 gpio_write[31:23] ignored
//                 leds              registered LED drive
//                 pwm_sync          one-cycle pulse at each PWM period start
//
// Build option: define LED_GAMMA_EN to take the duty from a 16-entry gamma
// table instead of the linear lvl*17 mapping.
module gpio_led_driver #(
  parameter int unsigned PRESCALE_DIV = 50,
  parameter int unsigned NUM_LEDS     = 8
) (
  input  logic     clk_50MHz,
  input  logic     rst,
  gpio_led_if.slave bus
);

  localparam int unsigned PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int unsigned CW = NUM_LEDS + 15;  // en, blink, lvl, rate

  logic [CW-1:0]       cfg_live_q,   cfg_live_d;
  logic [CW-1:0]       cfg_shadow_q, cfg_shadow_d;
  logic [PW-1:0]       presc_cnt_q,  presc_cnt_d;
  logic [7:0]          pwm_cnt_q,    pwm_cnt_d;
  logic [13:0]         blk_cnt_q,    blk_cnt_d;
  logic [NUM_LEDS-1:0] leds_q,       leds_d;
  logic                pwm_sync_q,   pwm_sync_d;

  logic                tick;
  logic                wrap;
  logic [NUM_LEDS-1:0] en;
  logic [NUM_LEDS-1:0] blink;
  logic [3:0]          lvl;
  logic [2:0]          rate;
  logic [7:0]          duty;
  logic                pwm_on;
  logic [3:0]          phase_idx;
  logic                phase;

  logic unused_hi;
  assign unused_hi = ^bus.gpio_write[31:CW];

  assign en    = cfg_shadow_q[NUM_LEDS-1:0];
  assign blink = cfg_shadow_q[2*NUM_LEDS-1:NUM_LEDS];
  assign lvl   = cfg_shadow_q[2*NUM_LEDS+3:2*NUM_LEDS];
  assign rate  = cfg_shadow_q[2*NUM_LEDS+6:2*NUM_LEDS+4];

`ifdef LED_GAMMA_EN
  always_comb begin
    duty = 8'd0;
    case (lvl)
      4'd0:  duty = 8'd0;
      4'd1:  duty = 8'd1;
      4'd2:  duty = 8'd2;
      4'd3:  duty = 8'd4;
      4'd4:  duty = 8'd6;
      4'd5:  duty = 8'd9;
      4'd6:  duty = 8'd13;
      4'd7:  duty = 8'd18;
      4'd8:  duty = 8'd25;
      4'd9:  duty = 8'd34;
      4'd10: duty = 8'd46;
      4'd11: duty = 8'd62;
      4'd12: duty = 8'd84;
      4'd13: duty = 8'd113;
      4'd14: duty = 8'd152;
      default: duty = 8'd255;
    endcase
  end
`else
  // lvl*17 == (lvl<<4) + lvl, i.e. the nibble repeated.
  assign duty = {lvl, lvl};
`endif

  // duty==255 is forced fully on so the top level has no dark cycle.
  assign pwm_on = (pwm_cnt_q < duty) || (duty == 8'hFF);

  assign phase_idx = {1'b0, rate} + 4'd6;
  assign phase     = blk_cnt_q[phase_idx];

  assign tick = (presc_cnt_q == PW'(PRESCALE_DIV - 1));
  assign wrap = tick && (pwm_cnt_q == 8'hFF);

  always_comb begin
    cfg_live_d   = bus.gpio_write[CW-1:0];
    presc_cnt_d  = tick ? '0 : presc_cnt_q + 1'b1;
    pwm_cnt_d    = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    cfg_shadow_d = wrap ? cfg_live_q : cfg_shadow_q;
    blk_cnt_d    = wrap ? blk_cnt_q + 14'd1 : blk_cnt_q;
    pwm_sync_d   = wrap;
    leds_d       = en & (~blink | {NUM_LEDS{phase}}) & {NUM_LEDS{pwm_on}};
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      cfg_live_q   <= '0;
      cfg_shadow_q <= '0;
      presc_cnt_q  <= '0;
      pwm_cnt_q    <= '0;
      blk_cnt_q    <= '0;
      leds_q       <= '0;
      pwm_sync_q   <= 1'b0;
    end else begin
      cfg_live_q   <= cfg_live_d;
      cfg_shadow_q <= cfg_shadow_d;
      presc_cnt_q  <= presc_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      leds_q       <= leds_d;
      pwm_sync_q   <= pwm_sync_d;
    end
  end

  assign bus.leds     = leds_q;
  assign bus.pwm_sync = pwm_sync_q;

endmodule
